// File: rtl/alu_writeback_pkg.sv
// Shared ALU flags header: flag bit positions and default datapath widths.
// Imported by the writeback stage and its result queue.
package alu_writeback_pkg;

    localparam int LDefault  = 16;
    localparam int RaDefault = 3;

    // Bit positions inside the architectural flags word
    localparam int DivisionHasRemainderIdx   = 0;
    localparam int DivisionByZeroIdx         = 1;
    localparam int DivisionOverflowIdx       = 2;
    localparam int MultiplicationOverflowIdx = 3;
    localparam int NoFlagsIdx                = 4;

    function automatic logic [LDefault-1:0] flagMask(input int idx);
        logic [LDefault-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/alu_writeback_wb_queue.sv
// Generic Depth-entry circular result queue {dest, data} with occupancy count and per-entry dest match.
// Latency: pushed entry visible at head next cycle. Backpressure: caller must not push when Count == Depth.
// Head outputs read storage combinationally and hold while not popped.
module wb_queue #(
    parameter int Aw    = 3,
    parameter int Dw    = 16,
    parameter int Depth = 2
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Push,
    input  logic [Aw-1:0]            PushDest,
    input  logic [Dw-1:0]            PushData,
    input  logic                     Pop,
    output logic [$clog2(Depth):0]   Count,
    output logic                     HeadValid,
    output logic [Aw-1:0]            HeadDest,
    output logic [Dw-1:0]            HeadData,
    input  logic [Aw-1:0]            QueryDest,
    output logic [Depth-1:0]         MatchVec
);
    localparam int Pw = $clog2(Depth);
    localparam int Cw = Pw + 1;

    logic [Aw-1:0] destMem [Depth];
    logic [Dw-1:0] dataMem [Depth];
    logic [Pw-1:0] wrPtr;
    logic [Pw-1:0] rdPtr;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            if (Push) wrPtr <= wrPtr + 1'b1;
            if (Pop)  rdPtr <= rdPtr + 1'b1;
            case ({Push, Pop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

    // Storage is deliberately not reset; occupancy alone defines validity
    always_ff @(posedge Clock) begin
        if (Push) begin
            destMem[wrPtr] <= PushDest;
            dataMem[wrPtr] <= PushData;
        end
    end

    assign HeadValid = (Count != '0);
    assign HeadDest  = destMem[rdPtr];
    assign HeadData  = dataMem[rdPtr];

    always_comb begin
        MatchVec = '0;
        for (int i = 0; i < Depth; i++) begin
            logic [Pw-1:0] offset;
            offset = Pw'(i) - rdPtr;
            MatchVec[i] = (Cw'(offset) < Count) && (destMem[i] == QueryDest);
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Execute-to-writeback stage: result queue to the register file, architectural flags register, hazard lookup.
// Latency: 1 cycle input to WbValid; 0 cycles when empty with ALU_WB_BYPASS_EN defined.
// Backpressure: InReady drops when Count == Depth (pre-drain); ALU holds inputs until accepted.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int l     = LDefault,
    parameter int ra    = RaDefault,
    parameter int Depth = 2
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [ra-1:0]            InDest,
    input  logic [l-1:0]             InR,
    input  logic [l-1:0]             InFlags,
    input  logic                     InCommitFlags,
    input  logic                     FlagsWrEn,
    input  logic [l-1:0]             FlagsWrData,
    output logic [l-1:0]             FlagsQ,
    output logic                     WbValid,
    input  logic                     WbReady,
    output logic [ra-1:0]            WbDest,
    output logic [l-1:0]             WbData,
    input  logic [ra-1:0]            QueryDest,
    output logic                     QueryHit,
    output logic [$clog2(Depth):0]   Count,
    output logic                     DivZeroEvent
);
    localparam int lv = l - 1;
    localparam int Cw = $clog2(Depth) + 1;

    logic             acc;
    logic             bypass;
    logic             qPush;
    logic             qPop;
    logic             qHeadValid;
    logic [ra-1:0]    qHeadDest;
    logic [lv:0]      qHeadData;
    logic [Depth-1:0] matchVec;
    logic             divZeroSet;

    assign InReady = (Count < Cw'(Depth));
    assign acc     = InValid & InReady;

`ifdef ALU_WB_BYPASS_EN
    assign bypass = (Count == '0) & InValid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry that the register file takes this cycle never enters storage
    assign qPush = acc & ~(bypass & WbReady);
    assign qPop  = qHeadValid & WbReady;

    wb_queue #(
        .Aw    (ra),
        .Dw    (l),
        .Depth (Depth)
    ) uQueue (
        .Clock     (Clock),
        .Reset     (Reset),
        .Push      (qPush),
        .PushDest  (InDest),
        .PushData  (InR),
        .Pop       (qPop),
        .Count     (Count),
        .HeadValid (qHeadValid),
        .HeadDest  (qHeadDest),
        .HeadData  (qHeadData),
        .QueryDest (QueryDest),
        .MatchVec  (matchVec)
    );

    assign WbValid  = qHeadValid | bypass;
    assign WbDest   = bypass ? InDest : qHeadDest;
    assign WbData   = bypass ? InR    : qHeadData;
    assign QueryHit = |matchVec;

    // Only a commit that actually lands (not overridden by software) can raise the event
    assign divZeroSet = acc & InCommitFlags & ~FlagsWrEn
                      & InFlags[DivisionByZeroIdx] & ~FlagsQ[DivisionByZeroIdx];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            FlagsQ       <= '0;
            DivZeroEvent <= 1'b0;
        end else begin
            if (FlagsWrEn)
                FlagsQ <= FlagsWrData;
            else if (acc && InCommitFlags)
                FlagsQ <= InFlags;
            DivZeroEvent <= divZeroSet;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: vector table for per-cycle behaviour, hand sequences for full/wrap/reset.
module tb_alu_writeback;

    logic        Clock;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [2:0]  InDest;
    logic [15:0] InR;
    logic [15:0] InFlags;
    logic        InCommitFlags;
    logic        FlagsWrEn;
    logic [15:0] FlagsWrData;
    logic [15:0] FlagsQ;
    logic        WbValid;
    logic        WbReady;
    logic [2:0]  WbDest;
    logic [15:0] WbData;
    logic [2:0]  QueryDest;
    logic        QueryHit;
    logic [1:0]  Count;
    logic        DivZeroEvent;

    int checks = 0;
    int errors = 0;

    alu_writeback #(.l(16), .ra(3), .Depth(2)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .InValid       (InValid),
        .InReady       (InReady),
        .InDest        (InDest),
        .InR           (InR),
        .InFlags       (InFlags),
        .InCommitFlags (InCommitFlags),
        .FlagsWrEn     (FlagsWrEn),
        .FlagsWrData   (FlagsWrData),
        .FlagsQ        (FlagsQ),
        .WbValid       (WbValid),
        .WbReady       (WbReady),
        .WbDest        (WbDest),
        .WbData        (WbData),
        .QueryDest     (QueryDest),
        .QueryHit      (QueryHit),
        .Count         (Count),
        .DivZeroEvent  (DivZeroEvent)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic        v;
        logic [2:0]  d;
        logic [15:0] r;
        logic [15:0] f;
        logic        c;
        logic        we;
        logic [15:0] wd;
        logic        rdy;
        logic [2:0]  q;
        logic        eV;
        logic [2:0]  eD;
        logic [15:0] eDat;
        logic [15:0] eF;
        logic [1:0]  eCnt;
        logic        eRdy;
        logic        eHit;
        logic        eDz;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idleInputs();
        InValid = 0; InDest = 0; InR = 0; InFlags = 0; InCommitFlags = 0;
        FlagsWrEn = 0; FlagsWrData = 0; WbReady = 0; QueryDest = 0;
    endtask

    task automatic push(input logic [2:0] d, input logic [15:0] r, input logic rdy);
        InValid = 1; InDest = d; InR = r; InCommitFlags = 0; WbReady = rdy;
        tick();
    endtask

    initial begin
        int got;
        logic [2:0] drained [3];

        //            v  d   r        f        c  we wd       rdy q  | eV eD eDat     eF       cnt rdy hit dz
        vecs[0]  = '{1, 3, 16'h0007, 16'h0001, 1, 0, 16'h0000, 1, 3,  1, 3, 16'h0007, 16'h0001, 1, 1, 1, 0};
        vecs[1]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 3,  0, 0, 16'h0000, 16'h0001, 0, 1, 0, 0};
        vecs[2]  = '{1, 4, 16'h0011, 16'h0002, 1, 1, 16'h00F0, 0, 4,  1, 4, 16'h0011, 16'h00F0, 1, 1, 1, 0};
        vecs[3]  = '{1, 5, 16'h0022, 16'h0002, 1, 0, 16'h0000, 0, 5,  1, 4, 16'h0011, 16'h0002, 2, 0, 1, 1};
        vecs[4]  = '{1, 6, 16'h0033, 16'hFFFF, 1, 0, 16'h0000, 0, 6,  1, 4, 16'h0011, 16'h0002, 2, 0, 0, 0};
        vecs[5]  = '{1, 6, 16'h0033, 16'hFFFF, 1, 0, 16'h0000, 1, 5,  1, 5, 16'h0022, 16'h0002, 1, 1, 1, 0};
        vecs[6]  = '{1, 6, 16'h0033, 16'hFFFF, 1, 0, 16'h0000, 1, 6,  1, 6, 16'h0033, 16'hFFFF, 1, 1, 1, 0};
        vecs[7]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 6,  0, 0, 16'h0000, 16'hFFFF, 0, 1, 0, 0};
        vecs[8]  = '{1, 7, 16'h0044, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 7, 16'h0044, 16'hFFFF, 1, 1, 0, 0};
        vecs[9]  = '{0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 7,  1, 7, 16'h0044, 16'h0000, 1, 1, 1, 0};
        vecs[10] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 7,  0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0};

        idleInputs();
        Reset = 1;
        tick();
        Reset = 0;
        check("reset.FlagsQ", 32'(FlagsQ), 0);
        check("reset.WbValid", 32'(WbValid), 0);
        check("reset.InReady", 32'(InReady), 1);
        check("reset.Count", 32'(Count), 0);
        check("reset.DivZeroEvent", 32'(DivZeroEvent), 0);

        for (int i = 0; i < 11; i++) begin
            InValid = vecs[i].v; InDest = vecs[i].d; InR = vecs[i].r; InFlags = vecs[i].f;
            InCommitFlags = vecs[i].c; FlagsWrEn = vecs[i].we; FlagsWrData = vecs[i].wd;
            WbReady = vecs[i].rdy; QueryDest = vecs[i].q;
            tick();
            check($sformatf("vec%0d.WbValid", i), 32'(WbValid), 32'(vecs[i].eV));
            if (vecs[i].eV) begin
                check($sformatf("vec%0d.WbDest", i), 32'(WbDest), 32'(vecs[i].eD));
                check($sformatf("vec%0d.WbData", i), 32'(WbData), 32'(vecs[i].eDat));
            end
            check($sformatf("vec%0d.FlagsQ", i), 32'(FlagsQ), 32'(vecs[i].eF));
            check($sformatf("vec%0d.Count", i), 32'(Count), 32'(vecs[i].eCnt));
            check($sformatf("vec%0d.InReady", i), 32'(InReady), 32'(vecs[i].eRdy));
            check($sformatf("vec%0d.QueryHit", i), 32'(QueryHit), 32'(vecs[i].eHit));
            check($sformatf("vec%0d.DivZeroEvent", i), 32'(DivZeroEvent), 32'(vecs[i].eDz));
        end
        idleInputs();

        // Full queue: third input must be held, then drain order 1,2,3
        push(3'd1, 16'h0101, 0);
        push(3'd2, 16'h0102, 0);
        check("full.InReady", 32'(InReady), 0);
        check("full.Count", 32'(Count), 2);
        push(3'd3, 16'h0103, 0);
        check("full.heldCount", 32'(Count), 2);
        WbReady = 1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            logic taken;
            if (WbValid) begin
                drained[got] = WbDest;
                got++;
            end
            taken = InValid && InReady;
            tick();
            if (taken) InValid = 0;
        end
        check("full.drainCount", 32'(got), 3);
        for (int k = 0; k < got; k++)
            check($sformatf("full.drainOrder%0d", k), 32'(drained[k]), 32'(k + 1));
        check("full.emptyAfter", 32'(Count), 0);
        idleInputs();

        // Sustained push+pop across pointer wrap
        for (int k = 0; k <= 10; k++) begin
            InValid = (k < 10);
            InDest = 3'(k);
            InR = 16'(k);
            WbReady = 1;
            if (k > 0) begin
                check($sformatf("wrap.WbValid%0d", k), 32'(WbValid), 1);
                check($sformatf("wrap.WbData%0d", k), 32'(WbData), 32'(k - 1));
                check($sformatf("wrap.Count%0d", k), 32'(Count), 1);
            end
            tick();
        end
        check("wrap.finalCount", 32'(Count), 0);
        idleInputs();

        // Reset while entries are queued
        InFlags = 16'h0002;
        InCommitFlags = 1;
        InValid = 1; InDest = 3'd5; InR = 16'h0055;
        tick();
        InCommitFlags = 0;
        InDest = 3'd2;
        tick();
        QueryDest = 3'd5;
        InValid = 0;
        #1;
        check("midq.QueryHit", 32'(QueryHit), 1);
        check("midq.Count", 32'(Count), 2);
        Reset = 1;
        InValid = 1;
        tick();
        Reset = 0;
        InValid = 0;
        check("midq.resetCount", 32'(Count), 0);
        check("midq.resetWbValid", 32'(WbValid), 0);
        check("midq.resetFlagsQ", 32'(FlagsQ), 0);
        check("midq.resetQueryHit", 32'(QueryHit), 0);
        tick();
        check("midq.staysEmpty", 32'(Count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute-to-writeback stage directly downstream of the ALU.
- Captures each ALU result (R) with its destination register index into a small result queue, and drains the queue to the register file through a valid/ready handshake.
- Owns the architectural flags register. Its output feeds back into the ALU's FlagsIn, and its contents are updated from the ALU's FlagsOut on each accepted operation.
- Provides a pending-destination hazard lookup for the issue logic.

Parameters:
- l, 16, data/flags word width (lv = l-1 internally)
- ra, 3, register-index width (8 architectural registers)
- Depth, 2, result queue entries; power of two, >= 2

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- InValid  in  1  ALU result valid this cycle
- InReady  out  1  queue can accept; high when Count < Depth
- InDest  in  ra  destination register index
- InR  in  l  ALU result R
- InFlags  in  l  ALU FlagsOut
- InCommitFlags  in  1  1 = write InFlags to the flags register on acceptance
- FlagsWrEn  in  1  software write of the full flags register
- FlagsWrData  in  l  data for the software write
- FlagsQ  out  l  architectural flags; wired to ALU FlagsIn
- WbValid  out  1  queue head valid
- WbReady  in  1  register file accepts the head
- WbDest  out  ra  head destination index
- WbData  out  l  head data
- QueryDest  in  ra  register index asked about by issue logic
- QueryHit  out  1  QueryDest matches any queued entry
- Count  out  $clog2(Depth)+1  queued entry count
- DivZeroEvent  out  1  one-cycle pulse on a new divide-by-zero

Behaviour:
- Reset (synchronous, active-high):
  - Count=0, read/write pointers=0, FlagsQ=0, WbValid=0, DivZeroEvent=0.
  - Queue contents are don't-care.
  - Reset mid-transfer discards all queued entries. No partial writeback occurs.
- Accept: acc = InValid & InReady.
  - {InDest, InR} is written at the write pointer; the pointer wraps modulo Depth.
  - InValid while InReady=0: the input is not taken. The ALU stage must hold its inputs.
- Drain: drn = WbValid & WbReady. The read pointer advances with wrap.
  - WbDest/WbData show the head entry combinationally from storage.
  - Outputs hold stable while WbValid & ~WbReady.
- Count update:
  - acc & drn: Count unchanged. This is legal when full, because InReady reflects pre-drain Count (no same-cycle enqueue-on-full). It is also legal when empty under the optional bypass.
  - Otherwise Count increments on acc and decrements on drn.
- Latency: accepted entry reaches WbValid the next cycle (1 cycle).
- Flags register, priority high to low:
  1. FlagsWrEn: FlagsQ <= FlagsWrData.
  2. acc & InCommitFlags: FlagsQ <= InFlags. The ALU already preserves unused/upper bits.
  3. Otherwise FlagsQ holds.
- Flags timing:
  - Flags update on acceptance, not drain, so a back-to-back ALU operation sees the new flags the next cycle.
  - If FlagsWrEn and a commit coincide, the software write wins and the ALU flags are lost. This is by design.
- DivZeroEvent: registered; high the cycle after a commit that sets bit DivisionByZeroIdx when FlagsQ had it 0.
- QueryHit: combinational OR over valid entries of (entry.dest == QueryDest).
  - An entry draining this cycle still counts.
  - An entry being accepted this cycle does not count.
- Full: InReady=0. Empty: WbValid=0.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- Defined:
  - When Count==0 and InValid is high, WbValid/WbDest/WbData are driven directly from the input (0-cycle latency).
  - If WbReady is also high, the entry is consumed without being stored and Count stays 0.
  - QueryHit still excludes the input.
- Undefined: latency is always 1 cycle, and WbValid depends only on the registered state.

Decomposition:
- Shared package/header (existing flags header, extended):
  - flag index constants DivisionHasRemainderIdx, DivisionByZeroIdx, DivisionOverflowIdx, MultiplicationOverflowIdx, NoFlagsIdx
  - default widths l=16, ra=3
- Sub-module wb_queue (generic Depth-entry circular FIFO with Count and per-entry match vector).
- The top level holds the flags register, event pulse and bypass mux.

Test Plan:
- Reset then idle: after Reset=1 for 1 cycle -> FlagsQ=0, WbValid=0, InReady=1, Count=0.
- Single op: InValid, InDest=3, InR=16'h0007, InFlags=16'h0001, InCommitFlags=1, WbReady=1 -> next cycle WbValid=1, WbDest=3, WbData=7, FlagsQ=16'h0001; following cycle Count=0.
- Backpressure/full: WbReady=0, push dest 1,2 -> InReady=0, Count=2; third InValid is held; raise WbReady -> drain order 1,2,3 with no loss.
- Wrap and concurrent: Depth=2, sustained push+pop for 10 ops with data 0..9 -> WbData sequence 0..9, Count stays 1.
- Flags priority: same cycle FlagsWrEn=1 with 16'h00F0 and commit 16'h0002 -> FlagsQ=16'h00F0, DivZeroEvent=0.
- Hazard/event: queue holds dest 5, QueryDest=5 -> QueryHit=1; commit with the DivisionByZero bit set from clear -> DivZeroEvent=1 for exactly one cycle. Assert Reset mid-queue -> Count=0 next cycle.
